saa1099_bus_writer: RTL

Bus-master sequencer that drives the SAA1099 CPU write port (cs_n, a0, wr_n, 8-bit data) from a queue of register-write commands. Each command is an (register address, data) pair. The block emits the address cycle and the data cycle with programmable setup, strobe and hold timing. It sits between a CPU-side or script-side command source and the saa1099 core, so that register loads can be queued without stalling the producer.

---
 rtl/saa1099_bus_writer_if.sv | 28 ++
 rtl/saa1099_bus_writer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/saa1099_bus_writer_if.sv
// Command-side handshake plus SAA1099 write-port signals of the bus writer.
// The writer itself uses the master modport; the command producer and bus observer use slave.
interface saa1099_bus_writer_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_addr;
  logic [7:0]    cmd_data;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          cs_n;
  logic          a0;
  logic          wr_n;
  logic [7:0]    dout;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data,
    output cmd_ready, fifo_level, busy, cs_n, a0, wr_n, dout
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data,
    input  cmd_ready, fifo_level, busy, cs_n, a0, wr_n, dout
  );
endinterface

// File: rtl/saa1099_bus_writer.sv
// Queues (register, data) writes and plays them onto the SAA1099 CPU port
// with ce-counted setup/strobe/hold timing, optionally skipping repeated address cycles.
module saa1099_bus_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int SETUP      = 1,
  parameter int PULSE      = 2,
  parameter int HOLD       = 1,
  parameter bit SKIP_ADDR  = 1'b1
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic                ce,
  saa1099_bus_writer_if.master bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [3:0] SETUP_LAST = 4'(SETUP - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_GAP} state_t;
  typedef enum logic {PH_DATA, PH_ADDR} phase_t;

  logic [12:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [4:0]    head_addr;
  logic [7:0]    head_data;

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  assign push  = bus.cmd_valid && !full;
  assign {head_addr, head_data} = fifo_mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.cmd_addr, bus.cmd_data};
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  state_t     state, state_nx;
  phase_t     phase, phase_nx;
  logic [3:0] tick_cnt, tick_cnt_nx;
  logic [4:0] last_addr, last_addr_nx;
  logic       last_valid, last_valid_nx;
  logic [4:0] work_addr, work_addr_nx;
  logic [7:0] work_data, work_data_nx;
  logic       cs_n_q, cs_n_nx;
  logic       a0_q, a0_nx;
  logic       wr_n_q, wr_n_nx;
  logic [7:0] dout_q, dout_nx;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= PH_DATA;
      tick_cnt   <= '0;
      last_addr  <= '0;
      last_valid <= 1'b0;
      work_addr  <= '0;
      work_data  <= '0;
      cs_n_q     <= 1'b1;
      a0_q       <= 1'b0;
      wr_n_q     <= 1'b1;
      dout_q     <= '0;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      tick_cnt   <= tick_cnt_nx;
      last_addr  <= last_addr_nx;
      last_valid <= last_valid_nx;
      work_addr  <= work_addr_nx;
      work_data  <= work_data_nx;
      cs_n_q     <= cs_n_nx;
      a0_q       <= a0_nx;
      wr_n_q     <= wr_n_nx;
      dout_q     <= dout_nx;
    end
  end

  // Nothing advances without ce, so the bus freezes cleanly while the FIFO keeps filling.
  always_comb begin
    state_nx      = state;
    phase_nx      = phase;
    tick_cnt_nx   = tick_cnt;
    last_addr_nx  = last_addr;
    last_valid_nx = last_valid;
    work_addr_nx  = work_addr;
    work_data_nx  = work_data;
    cs_n_nx       = cs_n_q;
    a0_nx         = a0_q;
    wr_n_nx       = wr_n_q;
    dout_nx       = dout_q;
    pop           = 1'b0;
    if (ce) begin
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            pop          = 1'b1;
            work_addr_nx = head_addr;
            work_data_nx = head_data;
            tick_cnt_nx  = '0;
            cs_n_nx      = 1'b0;
            state_nx     = ST_SETUP;
            if (SKIP_ADDR && last_valid && (head_addr == last_addr)) begin
              phase_nx = PH_DATA;
              a0_nx    = 1'b0;
              dout_nx  = head_data;
            end else begin
              phase_nx = PH_ADDR;
              a0_nx    = 1'b1;
              dout_nx  = {3'b000, head_addr};
            end
          end
        end
        ST_SETUP: begin
          if (tick_cnt == SETUP_LAST) begin
            tick_cnt_nx = '0;
            wr_n_nx     = 1'b0;
            state_nx    = ST_STROBE;
          end else begin
            tick_cnt_nx = tick_cnt + 4'd1;
          end
        end
        ST_STROBE: begin
          if (tick_cnt == PULSE_LAST) begin
            tick_cnt_nx = '0;
            wr_n_nx     = 1'b1;
            state_nx    = ST_HOLD;
          end else begin
            tick_cnt_nx = tick_cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          if (tick_cnt == HOLD_LAST) begin
            tick_cnt_nx = '0;
            cs_n_nx     = 1'b1;
            state_nx    = ST_GAP;
            if (phase == PH_ADDR) begin
              last_addr_nx  = work_addr;
              last_valid_nx = 1'b1;
            end
          end else begin
            tick_cnt_nx = tick_cnt + 4'd1;
          end
        end
        ST_GAP: begin
          // a0/dout only move here or in IDLE, i.e. while cs_n is high.
          if (phase == PH_ADDR) begin
            phase_nx    = PH_DATA;
            cs_n_nx     = 1'b0;
            a0_nx       = 1'b0;
            dout_nx     = work_data;
            tick_cnt_nx = '0;
            state_nx    = ST_SETUP;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.fifo_level = level;
  assign bus.busy       = !empty || (state != ST_IDLE);
  assign bus.cs_n       = cs_n_q;
  assign bus.a0         = a0_q;
  assign bus.wr_n       = wr_n_q;
  assign bus.dout       = dout_q;

endmodule
